// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: source handshakes and register-file write port of regfile_wb_ctrl
// pend_mask exists only when WB_PEND_SCOREBOARD_EN is defined.
interface regfile_wb_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        write_en;
    logic [4:0]  reg_dest;
    logic [31:0] write_back;
`ifdef WB_PEND_SCOREBOARD_EN
    logic [31:0] pend_mask;
`endif
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready, write_en, reg_dest, write_back
`ifdef WB_PEND_SCOREBOARD_EN
        , input pend_mask
`endif
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready, write_en, reg_dest, write_back
`ifdef WB_PEND_SCOREBOARD_EN
        , output pend_mask
`endif
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin write-back of ALU and load results through private 2-deep FIFOs
// Optional registered pending-destination mask under WB_PEND_SCOREBOARD_EN.
module regfile_wb_ctrl (
    input logic clk,
    input logic rst,
    regfile_wb_ctrl_if.slave bus
);
    localparam logic LD = 1'b1;
    logic [1:0]  valid, ready, push, pop, wp, rp, n_wp, n_rp;
    logic [4:0]  rd_in [2];
    logic [31:0] data_in [2];
    logic [4:0]  mem_rd [2][2], n_mem_rd [2][2];
    logic [31:0] mem_data [2][2], n_mem_data [2][2];
    logic [1:0]  cnt [2], n_cnt [2];
    logic        last_grant, n_last, gnt, sel, n_we;
    logic [4:0]  n_dest;
    logic [31:0] n_wb;
    assign valid      = {bus.ld_valid, bus.alu_valid};
    assign rd_in[0]   = bus.alu_rd;
    assign rd_in[1]   = bus.ld_rd;
    assign data_in[0] = bus.alu_data;
    assign data_in[1] = bus.ld_data;
    // ready looks at occupancy only, so a full FIFO never passes through on a pop
    assign ready[0]   = (cnt[0] != 2'd2) && !rst;
    assign ready[1]   = (cnt[1] != 2'd2) && !rst;
    assign bus.alu_ready = ready[0];
    assign bus.ld_ready  = ready[1];
    assign gnt = (cnt[0] != 2'd0) || (cnt[1] != 2'd0);
    assign sel = (cnt[0] != 2'd0 && cnt[1] != 2'd0) ? ~last_grant : (cnt[1] != 2'd0);
    always_comb begin
        n_mem_rd   = mem_rd;
        n_mem_data = mem_data;
        n_wp       = wp;
        n_rp       = rp;
        n_cnt      = cnt;
        push       = '0;
        pop        = '0;
        for (int s = 0; s < 2; s++) begin
            push[s] = valid[s] && ready[s] && (rd_in[s] != 5'd0);
            pop[s]  = gnt && (sel == 1'(s));
            n_rp[s] = pop[s] ? ~rp[s] : rp[s];
            n_wp[s] = push[s] ? ~wp[s] : wp[s];
            if (push[s]) begin
                n_mem_rd[s][wp[s]]   = rd_in[s];
                n_mem_data[s][wp[s]] = data_in[s];
            end
            n_cnt[s] = cnt[s] + {1'b0, push[s]} - {1'b0, pop[s]};
        end
        n_we   = gnt;
        n_dest = gnt ? mem_rd[sel][rp[sel]] : bus.reg_dest;
        n_wb   = gnt ? mem_data[sel][rp[sel]] : bus.write_back;
        n_last = gnt ? sel : last_grant;
    end
`ifdef WB_PEND_SCOREBOARD_EN
    logic [31:0] n_mask;
    // mask reflects the state being loaded, so it tracks enqueue and retire edges directly
    always_comb begin
        n_mask = '0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 2; k++)
                if (n_cnt[s] == 2'd2 || (n_cnt[s] == 2'd1 && 1'(k) == n_rp[s]))
                    n_mask[n_mem_rd[s][k]] = 1'b1;
        if (n_we)
            n_mask[n_dest] = 1'b1;
        n_mask[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            bus.pend_mask <= '0;
        else
            bus.pend_mask <= n_mask;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd         <= '{default: '0};
            mem_data       <= '{default: '0};
            cnt            <= '{default: '0};
            wp             <= '0;
            rp             <= '0;
            last_grant     <= LD;
            bus.write_en   <= 1'b0;
            bus.reg_dest   <= '0;
            bus.write_back <= '0;
        end else begin
            mem_rd         <= n_mem_rd;
            mem_data       <= n_mem_data;
            cnt            <= n_cnt;
            wp             <= n_wp;
            rp             <= n_rp;
            last_grant     <= n_last;
            bus.write_en   <= n_we;
            bus.reg_dest   <= n_dest;
            bus.write_back <= n_wb;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenarios checked against a queue-based write-back model
// Define WB_PEND_SCOREBOARD_EN to also exercise pend_mask.
module tb_regfile_wb_ctrl;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    regfile_wb_ctrl_if bus();
    regfile_wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    ent_t        qa[$], ql[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [31:0] m_wb = '0;
    logic        m_last = 1'b1;
    logic [4:0]  wlog[$];
    logic [31:0] wdat[$];
    int          wcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // model: one grant per edge from the pre-edge queues, then accept into non-full queues
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            ql.delete();
            m_we = 1'b0;
            m_dest = '0;
            m_wb = '0;
            m_last = 1'b1;
        end else begin
            bit ra, rl, take_ld;
            ent_t e;
            ra = qa.size() < 2;
            rl = ql.size() < 2;
            m_we = 1'b0;
            take_ld = (qa.size() > 0 && ql.size() > 0) ? (m_last == 1'b0) : (ql.size() > 0);
            if (qa.size() > 0 || ql.size() > 0) begin
                if (take_ld) e = ql.pop_front();
                else e = qa.pop_front();
                m_we = 1'b1;
                m_dest = e.rd;
                m_wb = e.d;
                m_last = take_ld;
            end
            if (bus.alu_valid && ra && bus.alu_rd != 5'd0) qa.push_back('{bus.alu_rd, bus.alu_data});
            if (bus.ld_valid && rl && bus.ld_rd != 5'd0) ql.push_back('{bus.ld_rd, bus.ld_data});
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("alu_ready", 32'(bus.alu_ready), 32'(qa.size() < 2 && !rst));
        chk("ld_ready", 32'(bus.ld_ready), 32'(ql.size() < 2 && !rst));
        chk("write_en", 32'(bus.write_en), 32'(m_we));
        chk("reg_dest", 32'(bus.reg_dest), 32'(m_dest));
        chk("write_back", bus.write_back, m_wb);
`ifdef WB_PEND_SCOREBOARD_EN
        begin
            logic [31:0] m;
            m = '0;
            foreach (qa[i]) m[qa[i].rd] = 1'b1;
            foreach (ql[i]) m[ql[i].rd] = 1'b1;
            if (m_we) m[m_dest] = 1'b1;
            m[0] = 1'b0;
            chk("pend_mask", bus.pend_mask, m);
        end
`endif
        if (bus.write_en) begin
            wlog.push_back(bus.reg_dest);
            wdat.push_back(bus.write_back);
            wcyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wlog.delete();
        wdat.delete();
        wcyc.delete();
    endtask

    task automatic chk_seq(input string name, input logic [4:0] exp[4]);
        chk({name, "_count"}, 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk(name, 32'(wlog[i]), 32'(exp[i]));
    endtask

    initial begin
        logic       hs;
        logic [4:0] fill_exp[4];
        logic [4:0] con_exp[4];
        fill_exp = '{5'd9, 5'd1, 5'd2, 5'd3};
        con_exp  = '{5'd1, 5'd3, 5'd2, 5'd4};
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
        repeat (2) step();
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'({bus.alu_ready, bus.ld_ready}), 32'd3);

        // single write: handshake at E, write_en in the cycle after E+1
        clear_log();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        step();
        #3;
        chk("single_we", 32'(bus.write_en), 32'd1);
        chk("single_dest", 32'(bus.reg_dest), 32'd5);
        chk("single_data", bus.write_back, 32'hDEADBEEF);
        step();
        #3;
        chk("single_we_low", 32'(bus.write_en), 32'd0);

        // fill and stall with a load buffered alongside
        step();
        clear_log();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h0000_0090;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0011;
        step();
        bus.ld_valid = 1'b0;
        bus.alu_rd = 5'd2; bus.alu_data = 32'h0000_0022;
        step();
        chk("stall_ready", 32'(bus.alu_ready), 32'd0);
        bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0033;
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) begin
            hs = bus.alu_ready;
            step();
        end
        chk("stall_handshake", 32'(hs), 32'd1);
        bus.alu_valid = 1'b0;
        repeat (4) step();
        chk_seq("fill_order", fill_exp);
        if (wdat.size() == 4) chk("fill_data3", wdat[3], 32'h0000_0033);

        // zero register: accepted, never written
        clear_log();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hFFFFFFFF;
        chk("zero_ready", 32'(bus.ld_ready), 32'd1);
        step();
        bus.ld_valid = 1'b0;
        repeat (3) step();
        chk("zero_writes", 32'(wlog.size()), 32'd0);

        // one load write so the LD source holds last_grant
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'h0000_00A0;
        step();
        bus.ld_valid = 1'b0;
        repeat (3) step();

        // contention: alternating ALU/LD retirement on consecutive cycles
        clear_log();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0101;
        bus.ld_valid = 1'b1;  bus.ld_rd = 5'd3;  bus.ld_data = 32'h0000_0303;
        step();
        bus.alu_rd = 5'd2; bus.alu_data = 32'h0000_0202;
        bus.ld_rd = 5'd4;  bus.ld_data = 32'h0000_0404;
        step();
        bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
        repeat (5) step();
        chk_seq("contention", con_exp);
        if (wcyc.size() == 4) chk("contention_span", 32'(wcyc[3] - wcyc[0]), 32'd3);

        // reset pulsed between edges with three entries buffered
        clear_log();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h0000_0020;
        bus.ld_valid = 1'b1;  bus.ld_rd = 5'd21;  bus.ld_data = 32'h0000_0021;
        step();
        bus.alu_rd = 5'd22; bus.ld_rd = 5'd23;
        step();
        bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
        chk("pre_rst_we", 32'(bus.write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.write_en), 32'd0);
        chk("mid_rst_dest", 32'(bus.reg_dest), 32'd0);
        chk("mid_rst_wb", bus.write_back, 32'd0);
        chk("mid_rst_ready", 32'({bus.alu_ready, bus.ld_ready}), 32'd0);
        rst = 1'b0;
        step();
        chk("post_pulse_ready", 32'({bus.alu_ready, bus.ld_ready}), 32'd3);
        repeat (4) step();
        chk("post_rst_writes", 32'(wlog.size()), 32'd0);

`ifdef WB_PEND_SCOREBOARD_EN
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_0007;
        step();
        bus.alu_valid = 1'b0;
        #3;
        chk("pend_enq", 32'(bus.pend_mask[7]), 32'd1);
        step();
        #3;
        chk("pend_write", 32'(bus.pend_mask[7]), 32'd1);
        step();
        #3;
        chk("pend_clear", bus.pend_mask, 32'd0);
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
